// File: rtl/sdr_tx.sv
// sdr_tx: I3C SDR transmit serializer, MSB-first byte, T-bit, 0/1 bit.
// Ports: i_clk, i_rst (sync, high), i_tx_en, i_tx_mode[2:0],
//   i_regf_data, i_scl_neg_edge (launch strobe), o_sda,
//   o_tx_mode_done (1-cycle pulse with last bit), o_busy (in SHIFT).
// Option: SDR_TX_PARITY_EN enables PARITY mode (3'b011) and par_byte.
module sdr_tx #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_tx_en,
  input  logic [2:0]            i_tx_mode,
  input  logic [DATA_WIDTH-1:0] i_regf_data,
  input  logic                  i_scl_neg_edge,
  output logic                  o_sda,
  output logic                  o_tx_mode_done,
  output logic                  o_busy
);

  localparam int CW = $clog2(DATA_WIDTH);

  localparam logic [2:0] MODE_SER  = 3'b001;
  localparam logic [2:0] MODE_ZERO = 3'b010;
  localparam logic [2:0] MODE_ONE  = 3'b100;
`ifdef SDR_TX_PARITY_EN
  localparam logic [2:0] MODE_PAR  = 3'b011;
`endif

  typedef enum logic {
    S_IDLE,
    S_SHIFT
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  sda_q, sda_d;
  logic                  done_q, done_d;
`ifdef SDR_TX_PARITY_EN
  logic [DATA_WIDTH-1:0] par_q, par_d;
`endif

  // State and datapath registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      sda_q   <= 1'b1;
      done_q  <= 1'b0;
`ifdef SDR_TX_PARITY_EN
      par_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      sda_q   <= sda_d;
      done_q  <= done_d;
`ifdef SDR_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  // Next state; abort (enable low) beats a same-cycle strobe
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (i_scl_neg_edge && i_tx_en &&
            i_tx_mode == MODE_SER)
          state_d = S_SHIFT;
      end
      S_SHIFT: begin
        if (!i_tx_en)
          state_d = S_IDLE;
        else if (i_scl_neg_edge && cnt_q == '0)
          state_d = S_IDLE;
      end
    endcase
  end

  // Outputs and datapath; SDA holds between launch edges
  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    sda_d   = sda_q;
    done_d  = 1'b0;
`ifdef SDR_TX_PARITY_EN
    par_d   = par_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (i_scl_neg_edge) begin
          sda_d = 1'b1;
          if (i_tx_en) begin
            case (i_tx_mode)
              MODE_SER: begin
                shift_d = i_regf_data;
                sda_d   = i_regf_data[DATA_WIDTH-1];
                cnt_d   = CW'(DATA_WIDTH - 2);
`ifdef SDR_TX_PARITY_EN
                par_d   = i_regf_data;
`endif
              end
`ifdef SDR_TX_PARITY_EN
              MODE_PAR: begin
                sda_d  = ~^par_q;
                done_d = 1'b1;
              end
`endif
              MODE_ZERO: begin
                sda_d  = 1'b0;
                done_d = 1'b1;
              end
              MODE_ONE: begin
                done_d = 1'b1;
              end
              default: ;
            endcase
          end
        end
      end
      S_SHIFT: begin
        if (!i_tx_en) begin
          sda_d = 1'b1;
        end else if (i_scl_neg_edge) begin
          sda_d = shift_q[cnt_q];
          if (cnt_q == '0)
            done_d = 1'b1;
          else
            cnt_d = cnt_q - 1'b1;
        end
      end
    endcase
  end

  assign o_sda          = sda_q;
  assign o_tx_mode_done = done_q;
  assign o_busy         = (state_q == S_SHIFT);

endmodule
